// File: rtl/sstl_bidir_bus_ctrl.sv
// Half-duplex master for a shared bidirectional bus built from per-bit tri-state I/O cells.
// Turns valid/ready read/write requests into I/T drive sequences and samples the pad value.
// On every direction change it inserts released-bus idle cycles, so the FPGA and the
// external device never drive the bus at the same time.
// Every output is a register loaded from the next-state logic. No input reaches an
// output without passing through a flop.
module sstl_bidir_bus_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TURNAROUND   = 1,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [WIDTH-1:0] bus_i,
    output logic [WIDTH-1:0] bus_t,
    input  logic [WIDTH-1:0] bus_o,
    output logic             bus_strobe
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StTurn   = 3'd1;
    localparam logic [2:0] StDrive  = 3'd2;
    localparam logic [2:0] StStrobe = 3'd3;
    localparam logic [2:0] StWait   = 3'd4;

    localparam logic DirRead  = 1'b0;
    localparam logic DirWrite = 1'b1;

    // Counters hold "cycles remaining minus one", so the exit is taken when they read zero.
    localparam logic [3:0] TurnLoad = 4'(TURNAROUND - 1);
    localparam logic [3:0] WaitLoad = 4'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    logic [2:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WIDTH-1:0] bus_i_q, bus_i_d;
    logic [WIDTH-1:0] bus_t_q, bus_t_d;
    logic             bus_strobe_q, bus_strobe_d;
    logic             sample;

    // Next state, plus the output values that belong to that next state.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        bus_i_d     = bus_i_q;
        rsp_rdata_d = rsp_rdata_q;
        sample      = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    // Load the write data now; during a turn the bus is released, so it
                    // does not matter that bus_i changes early.
                    if (req_write) begin
                        bus_i_d = req_wdata;
                    end
                    if (req_write != dir_q) begin
                        state_d = StTurn;
                        dir_d   = req_write;
                        cnt_d   = TurnLoad;
                    end else begin
                        state_d = req_write ? StDrive : StStrobe;
                    end
                end
            end
            StTurn: begin
                if (cnt_q == 4'd0) begin
                    state_d = (dir_q == DirWrite) ? StDrive : StStrobe;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDrive: begin
                state_d = StIdle;
            end
            StStrobe: begin
                if (READ_LATENCY == 0) begin
                    sample  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    sample  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (sample) begin
            rsp_rdata_d = bus_o;
        end
        rsp_valid_d  = sample;
        req_ready_d  = (state_d == StIdle);
        bus_strobe_d = (state_d == StDrive) || (state_d == StStrobe);
        // Drive during DRIVE and keep driving while parked in write direction; release otherwise.
        bus_t_d      = ((state_d == StDrive) || ((state_d == StIdle) && (dir_d == DirWrite)))
                       ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end

    // State and registered outputs; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dir_q        <= DirRead;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= {WIDTH{1'b0}};
            bus_i_q      <= {WIDTH{1'b0}};
            bus_t_q      <= {WIDTH{1'b1}};
            bus_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            bus_i_q      <= bus_i_d;
            bus_t_q      <= bus_t_d;
            bus_strobe_q <= bus_strobe_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign bus_i      = bus_i_q;
    assign bus_t      = bus_t_q;
    assign bus_strobe = bus_strobe_q;

endmodule

// File: tb/tb_sstl_bidir_bus_ctrl.sv
// Directed bench for sstl_bidir_bus_ctrl: instance a uses the default parameters
// (TURNAROUND=1, READ_LATENCY=2); instance b uses TURNAROUND=3, READ_LATENCY=0.
// Cycle c starts at a rising edge. Inputs change 1 ns after that edge, and outputs
// are sampled on the falling edge.
module tb_sstl_bidir_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_bus_strobe;
    logic [7:0] a_req_wdata, a_rsp_rdata, a_bus_i, a_bus_t, a_bus_o;
    logic       b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_bus_strobe;
    logic [7:0] b_req_wdata, b_rsp_rdata, b_bus_i, b_bus_t, b_bus_o;

    int n_checks = 0;
    int n_fail   = 0;

    sstl_bidir_bus_ctrl #(.WIDTH(8), .TURNAROUND(1), .READ_LATENCY(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (a_req_write),
        .req_wdata  (a_req_wdata),
        .rsp_valid  (a_rsp_valid),
        .rsp_rdata  (a_rsp_rdata),
        .bus_i      (a_bus_i),
        .bus_t      (a_bus_t),
        .bus_o      (a_bus_o),
        .bus_strobe (a_bus_strobe)
    );

    sstl_bidir_bus_ctrl #(.WIDTH(8), .TURNAROUND(3), .READ_LATENCY(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_wdata  (b_req_wdata),
        .rsp_valid  (b_rsp_valid),
        .rsp_rdata  (b_rsp_rdata),
        .bus_i      (b_bus_i),
        .bus_t      (b_bus_t),
        .bus_o      (b_bus_o),
        .bus_strobe (b_bus_strobe)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic rdy, input logic stb,
                         input logic [7:0] t, input logic rv);
        check_eq({tag, ".ready"},  {7'd0, a_req_ready},  {7'd0, rdy});
        check_eq({tag, ".strobe"}, {7'd0, a_bus_strobe}, {7'd0, stb});
        check_eq({tag, ".bus_t"},  a_bus_t, t);
        check_eq({tag, ".rsp_v"},  {7'd0, a_rsp_valid},  {7'd0, rv});
    endtask

    task automatic chk_b(input string tag, input logic rdy, input logic stb,
                         input logic [7:0] t, input logic rv);
        check_eq({tag, ".ready"},  {7'd0, b_req_ready},  {7'd0, rdy});
        check_eq({tag, ".strobe"}, {7'd0, b_bus_strobe}, {7'd0, stb});
        check_eq({tag, ".bus_t"},  b_bus_t, t);
        check_eq({tag, ".rsp_v"},  {7'd0, b_rsp_valid},  {7'd0, rv});
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_wdata = 8'h00; a_bus_o = 8'h00;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_wdata = 8'h00; b_bus_o = 8'h00;

        // Reset values
        repeat (2) mid();
        chk_a("rst", 1'b1, 1'b0, 8'hFF, 1'b0);
        check_eq("rst.rdata", a_rsp_rdata, 8'h00);
        check_eq("rst.bus_i", a_bus_i, 8'h00);
        chk_b("rst_b", 1'b1, 1'b0, 8'hFF, 1'b0);
        next_cyc(); rst_n = 1'b1;

        // Read straight after reset: no turnaround, sample after 2 wait cycles
        next_cyc(); a_req_valid = 1'b1; a_req_write = 1'b0; a_bus_o = 8'hA5;
        mid(); chk_a("rd c0", 1'b1, 1'b0, 8'hFF, 1'b0);
        next_cyc(); a_req_valid = 1'b0;
        mid(); chk_a("rd c1", 1'b0, 1'b1, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rd c2", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rd c3", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rd c4", 1'b1, 1'b0, 8'hFF, 1'b1);
        check_eq("rd c4.rdata", a_rsp_rdata, 8'hA5);
        next_cyc(); a_bus_o = 8'h00;
        mid(); chk_a("rd c5", 1'b1, 1'b0, 8'hFF, 1'b0);
        check_eq("rd c5.rdata hold", a_rsp_rdata, 8'hA5);

        // Reset, then write 3C: one turn cycle, then drive, then park driven
        next_cyc(); rst_n = 1'b0;
        next_cyc(); rst_n = 1'b1;
        next_cyc(); a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h3C;
        next_cyc(); a_req_valid = 1'b0;
        mid(); chk_a("wr c1", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("wr c2", 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("wr c2.bus_i", a_bus_i, 8'h3C);
        for (int i = 3; i < 5; i++) begin
            next_cyc(); mid(); chk_a($sformatf("wr c%0d", i), 1'b1, 1'b0, 8'h00, 1'b0);
            check_eq($sformatf("wr c%0d.bus_i", i), a_bus_i, 8'h3C);
        end

        // Write 11, read, write 22 back-to-back with req_valid held high
        next_cyc(); a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h11; a_bus_o = 8'h5A;
        mid(); chk_a("b2b c0", 1'b1, 1'b0, 8'h00, 1'b0);
        next_cyc(); a_req_write = 1'b0;
        mid(); chk_a("b2b c1", 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("b2b c1.bus_i", a_bus_i, 8'h11);
        next_cyc(); mid(); chk_a("b2b c2", 1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("b2b c2.bus_i", a_bus_i, 8'h11);
        next_cyc(); a_req_write = 1'b1; a_req_wdata = 8'h22;
        mid(); chk_a("b2b c3", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("b2b c4", 1'b0, 1'b1, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("b2b c5", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("b2b c6", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("b2b c7", 1'b1, 1'b0, 8'hFF, 1'b1);
        check_eq("b2b c7.rdata", a_rsp_rdata, 8'h5A);
        next_cyc(); a_req_valid = 1'b0;
        mid(); chk_a("b2b c8", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("b2b c9", 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("b2b c9.bus_i", a_bus_i, 8'h22);
        next_cyc(); mid(); chk_a("b2b c10", 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset pulsed in the WAIT state of a read: no response may follow
        next_cyc(); a_req_valid = 1'b1; a_req_write = 1'b0; a_bus_o = 8'h66;
        next_cyc(); a_req_valid = 1'b0;
        mid(); chk_a("rw c1", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rw c2", 1'b0, 1'b1, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rw c3", 1'b0, 1'b0, 8'hFF, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_a("rw async", 1'b1, 1'b0, 8'hFF, 1'b0);
        check_eq("rw async.rdata", a_rsp_rdata, 8'h00);
        check_eq("rw async.bus_i", a_bus_i, 8'h00);
        next_cyc(); rst_n = 1'b1;
        for (int i = 4; i < 8; i++) begin
            mid(); chk_a($sformatf("rw c%0d", i), 1'b1, 1'b0, 8'hFF, 1'b0);
            next_cyc();
        end
        a_req_valid = 1'b1; a_req_write = 1'b0; a_bus_o = 8'h77;
        next_cyc(); a_req_valid = 1'b0;
        mid(); chk_a("rw2 c1", 1'b0, 1'b1, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rw2 c2", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rw2 c3", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("rw2 c4", 1'b1, 1'b0, 8'hFF, 1'b1);
        check_eq("rw2 c4.rdata", a_rsp_rdata, 8'h77);

        // A write presented while busy for one cycle is dropped
        next_cyc(); a_req_valid = 1'b1; a_req_write = 1'b0; a_bus_o = 8'hC3;
        next_cyc(); a_req_write = 1'b1; a_req_wdata = 8'h99;
        mid(); chk_a("drop c1", 1'b0, 1'b1, 8'hFF, 1'b0);
        next_cyc(); a_req_valid = 1'b0; a_req_write = 1'b0;
        mid(); chk_a("drop c2", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("drop c3", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_a("drop c4", 1'b1, 1'b0, 8'hFF, 1'b1);
        check_eq("drop c4.rdata", a_rsp_rdata, 8'hC3);
        for (int i = 5; i < 8; i++) begin
            next_cyc(); mid(); chk_a($sformatf("drop c%0d", i), 1'b1, 1'b0, 8'hFF, 1'b0);
            check_eq($sformatf("drop c%0d.bus_i", i), a_bus_i, 8'h00);
        end

        // Instance b: write 44 (three turn cycles), then read with zero read latency
        next_cyc(); b_req_valid = 1'b1; b_req_write = 1'b1; b_req_wdata = 8'h44;
        next_cyc(); b_req_valid = 1'b0;
        mid(); chk_b("b c1", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_b("b c2", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_b("b c3", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_b("b c4", 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("b c4.bus_i", b_bus_i, 8'h44);
        next_cyc(); b_req_valid = 1'b1; b_req_write = 1'b0; b_bus_o = 8'h11;
        mid(); chk_b("b c5", 1'b1, 1'b0, 8'h00, 1'b0);
        next_cyc(); b_req_valid = 1'b0;
        mid(); chk_b("b c6", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_b("b c7", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); mid(); chk_b("b c8", 1'b0, 1'b0, 8'hFF, 1'b0);
        next_cyc(); b_bus_o = 8'hE7;
        mid(); chk_b("b c9", 1'b0, 1'b1, 8'hFF, 1'b0);
        next_cyc(); b_bus_o = 8'h00;
        mid(); chk_b("b c10", 1'b1, 1'b0, 8'hFF, 1'b1);
        check_eq("b c10.rdata", b_rsp_rdata, 8'hE7);
        next_cyc(); mid(); chk_b("b c11", 1'b1, 1'b0, 8'hFF, 1'b0);
        check_eq("b c11.rdata hold", b_rsp_rdata, 8'hE7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
